// File: rtl/touch_keypad_n.sv
// touch_keypad_n
//   Turns a stream of touch-panel samples into debounced key events for one
//   horizontal row of rectangular on-screen keys. Only one key is tracked at a
//   time; a second key has to wait until the first is released.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   touch_valid  one-cycle strobe: touch_down/gr_x/gr_y carry a new sample
//   touch_down   panel reports contact in this sample
//   gr_x, gr_y   sample coordinates (pixels)
//   key_hit      raw geometric hit of the last valid sample (one-hot or zero)
//   key_press    one-cycle pulse on accepted press or auto-repeat
//   key_release  one-cycle pulse on accepted release
//   key_held     high while the tracked key is in the PRESSED state
//   key_toggle   per-key latch, flips on each accepted press (not on repeats)
//   key_code     index of the held key, zero when nothing is held
module touch_keypad_n #(
  parameter int NUM_KEYS   = 3,
  parameter int X0         = 11,
  parameter int Y0         = 11,
  parameter int KEY_W      = 90,
  parameter int KEY_H      = 80,
  parameter int PITCH      = 110,
  parameter int DEB_CNT    = 3,
  parameter int REL_CNT    = 2,
  parameter int REPEAT_EN  = 1,
  parameter int REPEAT_DLY = 10,
  parameter int REPEAT_PER = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                touch_valid,
  input  logic                touch_down,
  input  logic [10:0]         gr_x,
  input  logic [9:0]          gr_y,
  output logic [NUM_KEYS-1:0] key_hit,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_toggle,
  output logic [3:0]          key_code
);

  localparam logic [15:0] DEB_N    = 16'(DEB_CNT);
  localparam logic [15:0] REL_N    = 16'(REL_CNT);
  localparam logic [15:0] DLY_N    = 16'(REPEAT_DLY);
  localparam logic [15:0] PER_N    = 16'(REPEAT_PER);
  // Headroom below all-ones so the hold count can never wrap.
  localparam logic [15:0] HOLD_MAX = 16'hFFFF - PER_N;
  localparam logic [31:0] Y_LO     = 32'(Y0);
  localparam logic [31:0] Y_HI     = 32'(Y0 + KEY_H - 1);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL_WAIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cand_q, cand_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         rel_q, rel_d;
  logic [15:0]         hold_q, hold_d;
  logic [15:0]         rep_q, rep_d;
  logic [NUM_KEYS-1:0] key_hit_q, key_hit_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_release_q, key_release_d;
  logic [NUM_KEYS-1:0] key_toggle_q, key_toggle_d;

  logic                samp_found;
  logic [3:0]          samp_idx;
  logic                on_cand;
  logic                press_ev, rel_ev, accept_ev;
  logic [31:0]         x_ext, y_ext, lo_x, hi_x;

  // Geometric decode, 32-bit unsigned so region bounds never wrap. Scanning
  // downward lets the lowest matching key win.
  always_comb begin
    x_ext      = {21'd0, gr_x};
    y_ext      = {22'd0, gr_y};
    lo_x       = '0;
    hi_x       = '0;
    samp_found = 1'b0;
    samp_idx   = 4'd0;
    if (touch_down && (y_ext >= Y_LO) && (y_ext <= Y_HI)) begin
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
        lo_x = 32'(X0 + i * PITCH);
        hi_x = lo_x + 32'(KEY_W - 1);
        if ((x_ext >= lo_x) && (x_ext <= hi_x)) begin
          samp_found = 1'b1;
          samp_idx   = 4'(i);
        end
      end
    end
  end

  assign on_cand = samp_found && (samp_idx == cand_q);

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    key_hit_d = key_hit_q;
    press_ev  = 1'b0;
    rel_ev    = 1'b0;
    accept_ev = 1'b0;
    if (touch_valid) begin
      for (int j = 0; j < NUM_KEYS; j++) begin
        key_hit_d[j] = samp_found && (samp_idx == 4'(j));
      end
      case (state_q)
        IDLE: begin
          if (samp_found) begin
            cand_d = samp_idx;
            cnt_d  = 16'd1;
            if (DEB_N == 16'd1) begin
              state_d   = PRESSED;
              hold_d    = 16'd1;
              rep_d     = 16'd0;
              press_ev  = 1'b1;
              accept_ev = 1'b1;
            end else begin
              state_d = CAND;
            end
          end
        end
        CAND: begin
          if (on_cand) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == DEB_N) begin
              state_d   = PRESSED;
              hold_d    = cnt_q + 16'd1;
              rep_d     = 16'd0;
              press_ev  = 1'b1;
              accept_ev = 1'b1;
            end
          end else if (samp_found) begin
            cand_d = samp_idx;
            cnt_d  = 16'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 16'd0;
          end
        end
        PRESSED: begin
          if (on_cand) begin
            if (hold_q < HOLD_MAX) hold_d = hold_q + 16'd1;
            // First repeat fires when the hold count lands on the delay;
            // after that a separate phase counter paces the repeats, so
            // hold-count saturation cannot create or drop a repeat.
            if (REPEAT_EN != 0) begin
              if (hold_q < DLY_N) begin
                if (hold_q + 16'd1 == DLY_N) begin
                  press_ev = 1'b1;
                  rep_d    = 16'd0;
                end
              end else if (rep_q + 16'd1 >= PER_N) begin
                press_ev = 1'b1;
                rep_d    = 16'd0;
              end else begin
                rep_d = rep_q + 16'd1;
              end
            end
          end else if (REL_N == 16'd1) begin
            state_d = IDLE;
            rel_ev  = 1'b1;
            cnt_d   = 16'd0;
            hold_d  = 16'd0;
          end else begin
            state_d = REL_WAIT;
            rel_d   = 16'd1;
          end
        end
        REL_WAIT: begin
          // Any sample not on the tracked key counts toward release, so a
          // slide onto a neighbour releases the old key only.
          if (on_cand) begin
            state_d = PRESSED;
            rel_d   = 16'd0;
          end else if (rel_q + 16'd1 == REL_N) begin
            state_d = IDLE;
            rel_ev  = 1'b1;
            rel_d   = 16'd0;
            cnt_d   = 16'd0;
            hold_d  = 16'd0;
          end else begin
            rel_d = rel_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    key_press_d   = '0;
    key_release_d = '0;
    key_toggle_d  = key_toggle_q;
    for (int j = 0; j < NUM_KEYS; j++) begin
      key_press_d[j]   = press_ev && (cand_d == 4'(j));
      key_release_d[j] = rel_ev && (cand_d == 4'(j));
      if (accept_ev && (cand_d == 4'(j))) key_toggle_d[j] = ~key_toggle_q[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cand_q        <= 4'd0;
      cnt_q         <= 16'd0;
      rel_q         <= 16'd0;
      hold_q        <= 16'd0;
      rep_q         <= 16'd0;
      key_hit_q     <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      key_toggle_q  <= '0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      rel_q         <= rel_d;
      hold_q        <= hold_d;
      rep_q         <= rep_d;
      key_hit_q     <= key_hit_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_toggle_q  <= key_toggle_d;
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_KEYS; j++) begin
      key_held[j] = (state_q == PRESSED) && (cand_q == 4'(j));
    end
  end

  assign key_code    = (state_q == PRESSED) ? cand_q : 4'd0;
  assign key_hit     = key_hit_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_toggle  = key_toggle_q;

endmodule
